// File: rtl/letter_pkg.sv
// Shared letter codes, home message and scroller FSM encoding.
// The seven-segment digit decoder keys off the same LTR_* codes.
package letter_pkg;

  localparam logic [2:0] LTR_H     = 3'd0;
  localparam logic [2:0] LTR_E     = 3'd1;
  localparam logic [2:0] LTR_L     = 3'd2;
  localparam logic [2:0] LTR_O     = 3'd3;
  localparam logic [2:0] LTR_BLANK = 3'd4;

  // H,E,L,L,O,_,_,_ from HEX7 (bits [23:21]) down to HEX0 (bits [2:0]).
  localparam logic [23:0] HOME_MSG = {LTR_H, LTR_E, LTR_L, LTR_L,
                                      LTR_O, LTR_BLANK, LTR_BLANK, LTR_BLANK};

  typedef enum logic [1:0] {
    ST_STOP = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  // HEX7 code wraps around to HEX0.
  function automatic logic [23:0] rot_left3(input logic [23:0] m);
    return {m[20:0], m[23:21]};
  endfunction

  // HEX0 code wraps around to HEX7.
  function automatic logic [23:0] rot_right3(input logic [23:0] m);
    return {m[2:0], m[23:3]};
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running 0..TICK_DIV-1 counter producing a one-cycle terminal-count pulse.
// TICK_DIV must be at least 2.
module tick_prescaler #(
  parameter int TICK_DIV = 25_000_000
) (
  input  logic Clock,
  input  logic Reset,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          w_at_last;

  assign w_at_last = (r_cnt == LAST);
  // clr wins over a coincident terminal count so callers never see a stale pulse.
  assign tc = en & ~clr & w_at_last;

  // Count while enabled, wrap to 0 at the terminal count, clear on request.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en) begin
      if (w_at_last) r_cnt <= '0;
      else           r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/letter_scroller.sv
// Scrolls "HELLO" across eight 3-bit letter slots, one rotation per TICK_DIV
// cycles, dwelling HOLD_STEPS step periods whenever the message is back home.
module letter_scroller
  import letter_pkg::*;
#(
  parameter int TICK_DIV   = 25_000_000,
  parameter int HOLD_STEPS = 2
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Run,
  input  logic        Dir,
  input  logic        Clear,
  output logic [23:0] Letters,
  output logic        Step,
  output logic        Aligned,
  output state_t      o_state
);

  state_t      r_state;
  state_t      w_next;
  logic [23:0] r_letters;
  logic [2:0]  r_pos;
  logic        r_step;
  logic        r_aligned;
  logic [31:0] r_hold;

  logic        w_en;
  logic        w_clr;
  logic        w_tc;
  logic        w_rot;
  logic [23:0] w_rot_msg;
  logic [2:0]  w_rot_pos;
  logic        w_hold_done;

  // Prescaler only runs in RUN/HOLD; dropping Run or Clear zeroes it at once.
  assign w_en  = (r_state != ST_STOP);
  assign w_clr = Clear | ~Run | (r_state == ST_STOP);

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .Clock (Clock),
    .Reset (Reset),
    .clr   (w_clr),
    .en    (w_en),
    .tc    (w_tc)
  );

  // Dir is only looked at here, so it takes effect at the terminal-count edge.
  assign w_rot       = w_tc & (r_state == ST_RUN);
  assign w_rot_msg   = Dir ? rot_right3(r_letters) : rot_left3(r_letters);
  assign w_rot_pos   = Dir ? (r_pos - 3'd1) : (r_pos + 3'd1);
  assign w_hold_done = w_tc & (r_hold == 32'(HOLD_STEPS - 1));

  // State register.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) r_state <= ST_STOP;
    else       r_state <= w_next;
  end

  // Next-state logic; Clear overrides everything but keeps RUN if Run is high.
  always_comb begin
    w_next = r_state;
    if (Clear) begin
      w_next = Run ? ST_RUN : ST_STOP;
    end else begin
      case (r_state)
        ST_STOP: if (Run) w_next = ST_RUN;
        ST_RUN: begin
          if (!Run)                                          w_next = ST_STOP;
          else if (w_rot && w_rot_pos == 3'd0 && HOLD_STEPS > 0) w_next = ST_HOLD;
        end
        ST_HOLD: begin
          if (!Run)            w_next = ST_STOP;
          else if (w_hold_done) w_next = ST_RUN;
        end
        default: w_next = ST_STOP;
      endcase
    end
  end

  // Counts completed step periods while dwelling; zero whenever not in HOLD.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_hold <= '0;
    end else if (r_state == ST_HOLD && w_next == ST_HOLD) begin
      if (w_tc) r_hold <= r_hold + 32'd1;
    end else begin
      r_hold <= '0;
    end
  end

  // Rotation register, position counter and registered status outputs.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_letters <= HOME_MSG;
      r_pos     <= 3'd0;
      r_step    <= 1'b0;
      r_aligned <= 1'b1;
    end else if (Clear) begin
      r_letters <= HOME_MSG;
      r_pos     <= 3'd0;
      r_step    <= 1'b0;
      r_aligned <= 1'b1;
    end else if (w_rot) begin
      r_letters <= w_rot_msg;
      r_pos     <= w_rot_pos;
      r_step    <= 1'b1;
      r_aligned <= (w_rot_pos == 3'd0);
    end else begin
      r_step    <= 1'b0;
    end
  end

  assign Letters = r_letters;
  assign Step    = r_step;
  assign Aligned = r_aligned;
  assign o_state = r_state;

endmodule

// File: tb/tb_letter_scroller.sv
// Directed bench for letter_scroller with TICK_DIV=4, HOLD_STEPS=2.
module tb_letter_scroller;
  import letter_pkg::*;

  localparam int TD = 4;
  localparam int HS = 2;
  localparam logic [23:0] HOME = 24'h052724;
  localparam logic [23:0] L1   = 24'h293920;
  localparam logic [23:0] L2   = 24'h49C901;
  localparam logic [23:0] R1   = 24'h80A4E4;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        Run   = 1'b0;
  logic        Dir   = 1'b0;
  logic        Clear = 1'b0;
  logic [23:0] Letters;
  logic        Step;
  logic        Aligned;
  state_t      dut_state;

  int n_vec = 0;
  int n_err = 0;

  letter_scroller #(.TICK_DIV(TD), .HOLD_STEPS(HS)) dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .Run     (Run),
    .Dir     (Dir),
    .Clear   (Clear),
    .Letters (Letters),
    .Step    (Step),
    .Aligned (Aligned),
    .o_state (dut_state)
  );

  // Clock / reset block
  always #5 Clock = ~Clock;

  // Checking task: every comparison goes through here.
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Clock until Step is seen; n = cycles taken, -1 if the budget runs out.
  task automatic wait_step(output int n);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (Step) begin
        n = i;
        break;
      end
    end
  endtask

  // Clock k cycles and report how many of them carried a Step pulse.
  task automatic count_steps(input int k, output int s);
    s = 0;
    for (int i = 0; i < k; i++) begin
      tick();
      if (Step) s++;
    end
  endtask

  int n;
  int s;
  logic [23:0] frozen;

  initial begin
    // Reset: outputs go home asynchronously.
    #2 Reset = 1'b1;
    #2;
    chk("rst_letters", 32'(Letters), 32'(HOME));
    chk("rst_aligned", 32'(Aligned), 32'd1);
    chk("rst_step",    32'(Step),    32'd0);
    chk("rst_state",   32'(dut_state), 32'(ST_STOP));
    tick();
    Reset = 1'b0;
    count_steps(20, s);
    chk("idle_no_step", 32'(s), 32'd0);
    chk("idle_state",   32'(dut_state), 32'(ST_STOP));

    // Left scroll: first step exactly TD cycles after entering RUN.
    Run = 1'b1; Dir = 1'b0;
    tick();
    chk("run_state", 32'(dut_state), 32'(ST_RUN));
    wait_step(n);
    chk("first_step_lat", 32'(n), 32'(TD));
    chk("left1_letters",  32'(Letters), 32'(L1));
    chk("left1_aligned",  32'(Aligned), 32'd0);

    // Seven more left steps bring the message home and enter HOLD.
    for (int k = 2; k <= 8; k++) begin
      wait_step(n);
      chk("left_period", 32'(n), 32'(TD));
    end
    chk("home_letters", 32'(Letters), 32'(HOME));
    chk("home_aligned", 32'(Aligned), 32'd1);
    chk("hold_state",   32'(dut_state), 32'(ST_HOLD));
    count_steps(HS * TD, s);
    chk("hold_no_step", 32'(s), 32'd0);
    chk("hold_to_run",  32'(dut_state), 32'(ST_RUN));
    wait_step(n);
    chk("post_hold_lat", 32'(n), 32'(TD));
    chk("post_hold_letters", 32'(Letters), 32'(L1));

    // Drop Run mid-period: display freezes, re-run restarts the period.
    tick(); tick();
    Run = 1'b0;
    tick();
    chk("stop_state", 32'(dut_state), 32'(ST_STOP));
    frozen = Letters;
    count_steps(10, s);
    chk("stop_no_step", 32'(s), 32'd0);
    chk("stop_frozen",  32'(Letters), 32'(L1));
    Run = 1'b1;
    tick();
    wait_step(n);
    chk("rerun_lat",     32'(n), 32'(TD));
    chk("rerun_letters", 32'(Letters), 32'(L2));

    // Clear with Run=1 returns home and stays in RUN; then a right step.
    Clear = 1'b1;
    tick();
    Clear = 1'b0;
    chk("clr_letters", 32'(Letters), 32'(HOME));
    chk("clr_aligned", 32'(Aligned), 32'd1);
    chk("clr_state",   32'(dut_state), 32'(ST_RUN));
    Dir = 1'b1;
    wait_step(n);
    chk("right_lat",     32'(n), 32'(TD));
    chk("right_letters", 32'(Letters), 32'(R1));
    chk("right_aligned", 32'(Aligned), 32'd0);

    // Dir flipped mid-period applies to the next step (left back to home).
    tick(); tick();
    Dir = 1'b0;
    wait_step(n);
    chk("dir_mid_lat",     32'(n), 32'(TD - 2));
    chk("dir_mid_letters", 32'(Letters), 32'(HOME));
    chk("dir_mid_hold",    32'(dut_state), 32'(ST_HOLD));

    // Run dropped mid-HOLD abandons the dwell.
    tick(); tick(); tick();
    Run = 1'b0;
    tick();
    chk("hold_stop_state",   32'(dut_state), 32'(ST_STOP));
    chk("hold_stop_letters", 32'(Letters), 32'(HOME));
    Run = 1'b1;
    tick();
    wait_step(n);
    chk("hold_rerun_lat",     32'(n), 32'(TD));
    chk("hold_rerun_letters", 32'(Letters), 32'(L1));

    // Clear coincident with terminal count: Clear wins, no Step.
    tick(); tick(); tick();
    Clear = 1'b1;
    tick();
    Clear = 1'b0;
    chk("clr_tc_letters", 32'(Letters), 32'(HOME));
    chk("clr_tc_step",    32'(Step), 32'd0);
    chk("clr_tc_state",   32'(dut_state), 32'(ST_RUN));
    wait_step(n);
    chk("clr_tc_next_lat", 32'(n), 32'(TD));

    // Clear with Run=0 lands in STOP.
    Run = 1'b0; Clear = 1'b1;
    tick();
    Clear = 1'b0;
    chk("clr_stop_state",   32'(dut_state), 32'(ST_STOP));
    chk("clr_stop_letters", 32'(Letters), 32'(HOME));

    // Async reset between edges while Step is high.
    Run = 1'b1;
    tick();
    wait_step(n);
    chk("pre_rst_letters", 32'(Letters), 32'(L1));
    #1 Reset = 1'b1;
    #1;
    chk("async_rst_letters", 32'(Letters), 32'(HOME));
    chk("async_rst_step",    32'(Step),    32'd0);
    chk("async_rst_aligned", 32'(Aligned), 32'd1);
    chk("async_rst_state",   32'(dut_state), 32'(ST_STOP));
    tick();
    Reset = 1'b0; Run = 1'b0;
    count_steps(6, s);
    chk("post_rst_idle", 32'(dut_state), 32'(ST_STOP));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
